// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, requester IDs and the one-hot helper for the writeback arbiter.
// Register x0 is hardwired to zero, so it never appears in a one-hot mask.
package regfile_wb_arbiter_pkg;

  localparam int XLEN     = 64;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  typedef enum logic {
    REQ_LD  = 1'b0,
    REQ_ALU = 1'b1
  } req_id_e;

  // x0 is masked off so that writes to it never mark anything as pending.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_AW-1:0] addr);
    logic [NUM_REGS-1:0] v;
    v       = '0;
    v[addr] = 1'b1;
    v[0]    = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/regfile_wb_ldq.sv
// Load-writeback FIFO. The head is read combinationally so that it can be granted in the same cycle.
// A push that arrives while the FIFO is full is accepted only if the head is popped in the same cycle.
module regfile_wb_ldq
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_push,
  input  logic [REG_AW-1:0]            i_push_addr,
  input  logic [XLEN-1:0]              i_push_data,
  input  logic                         i_pop,
  output logic [REG_AW-1:0]            o_head_addr,
  output logic [XLEN-1:0]              o_head_data,
  output logic                         o_full,
  output logic                         o_empty,
  output logic                         o_drop,
  output logic [DEPTH-1:0]             o_entry_valid,
  output logic [DEPTH-1:0][REG_AW-1:0] o_entry_addr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [REG_AW-1:0] r_addr_mem [DEPTH];
  logic [XLEN-1:0]   r_data_mem [DEPTH];
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;
  logic              w_do_pop;
  logic              w_do_push;

  assign o_full      = (r_count == CW'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign w_do_pop    = i_pop && !o_empty;
  assign w_do_push   = i_push && (!o_full || w_do_pop);
  assign o_drop      = i_push && o_full && !w_do_pop;
  assign o_head_addr = r_addr_mem[r_rd_ptr];
  assign o_head_data = r_data_mem[r_rd_ptr];

  // When the FIFO is full, the write slot is the head being popped, so it is overwritten after it has been read.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_addr_mem[r_wr_ptr] <= i_push_addr;
      r_data_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_do_push && !w_do_pop)
        r_count <= r_count + CW'(1);
      else if (!w_do_push && w_do_pop)
        r_count <= r_count - CW'(1);
    end
  end

  // A slot is live when its distance from the read pointer is below the occupancy.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [PW-1:0] w_off;
    assign w_off             = PW'(gi) - r_rd_ptr;
    assign o_entry_valid[gi] = (CW'(w_off) < r_count);
    assign o_entry_addr[gi]  = r_addr_mem[gi];
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates a single register-file write port between the ALU and a queued load return path.
// Grants are registered into the write stage and appear one cycle after the grant.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int LDQ_DEPTH = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_alu_valid,
  input  logic [REG_AW-1:0]   i_alu_addr,
  input  logic [XLEN-1:0]     i_alu_data,
  output logic                o_alu_ready,
  input  logic                i_ld_valid,
  input  logic [REG_AW-1:0]   i_ld_addr,
  input  logic [XLEN-1:0]     i_ld_data,
  input  logic                i_stall,
  output logic                o_write,
  output logic [REG_AW-1:0]   o_write_addr,
  output logic [XLEN-1:0]     o_write_data,
  output logic [NUM_REGS-1:0] o_pending,
  output logic                o_ld_overflow
);

  logic [REG_AW-1:0]                w_head_addr;
  logic [XLEN-1:0]                  w_head_data;
  logic                             w_ld_full;
  logic                             w_ld_empty;
  logic                             w_ld_drop;
  logic [LDQ_DEPTH-1:0]             w_entry_valid;
  logic [LDQ_DEPTH-1:0][REG_AW-1:0] w_entry_addr;

  logic              w_gnt_ld;
  logic              w_gnt_alu;
  logic              w_contested;
  logic [REG_AW-1:0] w_gnt_addr;
  logic [XLEN-1:0]   w_gnt_data;
  req_id_e           r_rr_next;

  logic              r_write;
  logic [REG_AW-1:0] r_write_addr;
  logic [XLEN-1:0]   r_write_data;
  logic              r_ld_overflow;

  regfile_wb_ldq #(.DEPTH(LDQ_DEPTH)) u_ldq (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_push        (i_ld_valid),
    .i_push_addr   (i_ld_addr),
    .i_push_data   (i_ld_data),
    .i_pop         (w_gnt_ld),
    .o_head_addr   (w_head_addr),
    .o_head_data   (w_head_data),
    .o_full        (w_ld_full),
    .o_empty       (w_ld_empty),
    .o_drop        (w_ld_drop),
    .o_entry_valid (w_entry_valid),
    .o_entry_addr  (w_entry_addr)
  );

  assign w_contested = !w_ld_empty && i_alu_valid;

  // A full queue overrides round-robin and does not move the pointer.
  always_comb begin
    w_gnt_ld  = 1'b0;
    w_gnt_alu = 1'b0;
    if (!i_rst && !i_stall) begin
      if (w_ld_full)
        w_gnt_ld = 1'b1;
      else if (w_contested) begin
        if (r_rr_next == REQ_LD) w_gnt_ld  = 1'b1;
        else                     w_gnt_alu = 1'b1;
      end else if (!w_ld_empty)
        w_gnt_ld = 1'b1;
      else if (i_alu_valid)
        w_gnt_alu = 1'b1;
    end
  end

  assign w_gnt_addr  = w_gnt_ld ? w_head_addr : i_alu_addr;
  assign w_gnt_data  = w_gnt_ld ? w_head_data : i_alu_data;
  assign o_alu_ready = w_gnt_alu;

  always_ff @(posedge i_clk) begin
    if (i_rst)
      r_rr_next <= REQ_LD;
    else if (w_contested && !w_ld_full && !i_stall)
      r_rr_next <= w_gnt_ld ? REQ_ALU : REQ_LD;
  end

  // Grants to x0 are consumed but never reach the register file.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_write       <= 1'b0;
      r_write_addr  <= '0;
      r_write_data  <= '0;
      r_ld_overflow <= 1'b0;
    end else begin
      r_write <= (w_gnt_ld || w_gnt_alu) && (w_gnt_addr != '0);
      if (w_gnt_ld || w_gnt_alu) begin
        r_write_addr <= w_gnt_addr;
        r_write_data <= w_gnt_data;
      end
      if (w_ld_drop) r_ld_overflow <= 1'b1;
    end
  end

  always_comb begin
    o_pending = '0;
    for (int i = 0; i < LDQ_DEPTH; i++)
      if (w_entry_valid[i]) o_pending = o_pending | reg_onehot(w_entry_addr[i]);
    if (i_alu_valid) o_pending = o_pending | reg_onehot(i_alu_addr);
    if (r_write)     o_pending = o_pending | reg_onehot(r_write_addr);
  end

  assign o_write       = r_write;
  assign o_write_addr  = r_write_addr;
  assign o_write_data  = r_write_data;
  assign o_ld_overflow = r_ld_overflow;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: hand-computed vectors for arbitration, latency, x0, overflow and reset.
// Inputs change 1 ns after the rising edge, and outputs are checked before the next edge.
module tb_regfile_wb_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_alu_valid;
  logic [4:0]  i_alu_addr;
  logic [63:0] i_alu_data;
  logic        o_alu_ready;
  logic        i_ld_valid;
  logic [4:0]  i_ld_addr;
  logic [63:0] i_ld_data;
  logic        i_stall;
  logic        o_write;
  logic [4:0]  o_write_addr;
  logic [63:0] o_write_data;
  logic [31:0] o_pending;
  logic        o_ld_overflow;

  int n_checks = 0;
  int n_pass   = 0;

  regfile_wb_arbiter #(.LDQ_DEPTH(2)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_alu_valid   (i_alu_valid),
    .i_alu_addr    (i_alu_addr),
    .i_alu_data    (i_alu_data),
    .o_alu_ready   (o_alu_ready),
    .i_ld_valid    (i_ld_valid),
    .i_ld_addr     (i_ld_addr),
    .i_ld_data     (i_ld_data),
    .i_stall       (i_stall),
    .o_write       (o_write),
    .o_write_addr  (o_write_addr),
    .o_write_data  (o_write_data),
    .o_pending     (o_pending),
    .o_ld_overflow (o_ld_overflow)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish (got running, want finished)");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic do_reset;
    i_rst = 1'b1; i_alu_valid = 1'b0; i_ld_valid = 1'b0; i_stall = 1'b0;
    tick;
    i_rst = 1'b0;
  endtask

  task automatic ld_push(input logic [4:0] a, input logic [63:0] d);
    i_ld_valid = 1'b1; i_ld_addr = a; i_ld_data = d;
    tick;
    i_ld_valid = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_alu_valid = 1'b1; i_alu_addr = 5'd3; i_alu_data = 64'h1;
    i_ld_valid = 1'b0; i_ld_addr = '0; i_ld_data = '0; i_stall = 1'b0;
    tick;
    settle;
    check("rst_alu_ready", o_alu_ready, 0);
    tick;
    check("rst_write", o_write, 0);
    check("rst_waddr", o_write_addr, 0);
    check("rst_wdata", o_write_data, 0);
    check("rst_ovf", o_ld_overflow, 0);
    i_rst = 1'b0; i_alu_valid = 1'b0;
    settle;
    check("rst_pending", o_pending, 0);
    $display("reset: done");

    // ALU only
    i_alu_valid = 1'b1; i_alu_addr = 5'd5; i_alu_data = 64'hA5;
    settle;
    check("alu_ready", o_alu_ready, 1);
    check("alu_pend", o_pending, 32'h20);
    tick;
    i_alu_valid = 1'b0;
    settle;
    check("alu_write", o_write, 1);
    check("alu_waddr", o_write_addr, 5);
    check("alu_wdata", o_write_data, 64'hA5);
    check("alu_pend_out", o_pending, 32'h20);
    tick;
    check("alu_idle", o_write, 0);
    check("alu_pend_clr", o_pending, 0);
    $display("alu only: addr 5 data a5");

    // Contention: the load wins first, then the ALU
    ld_push(5'd3, 64'h33);
    i_alu_valid = 1'b1; i_alu_addr = 5'd7; i_alu_data = 64'h77;
    settle;
    check("ct_ready_c1", o_alu_ready, 0);
    check("ct_pend_c1", o_pending, 32'h88);
    tick;
    settle;
    check("ct_waddr_c2", o_write_addr, 3);
    check("ct_wdata_c2", o_write_data, 64'h33);
    check("ct_ready_c2", o_alu_ready, 1);
    check("ct_pend_c2", o_pending, 32'h88);
    tick;
    i_alu_valid = 1'b0;
    settle;
    check("ct_write_c3", o_write, 1);
    check("ct_waddr_c3", o_write_addr, 7);
    check("ct_wdata_c3", o_write_data, 64'h77);
    tick;
    check("ct_idle", o_write, 0);
    $display("contention: load 3 then alu 7");

    // Stall with overflow
    do_reset;
    i_stall = 1'b1;
    ld_push(5'd1, 64'h11);
    ld_push(5'd2, 64'h22);
    i_ld_addr = 5'd3; i_ld_data = 64'h33; i_ld_valid = 1'b1;
    settle;
    check("ov_before", o_ld_overflow, 0);
    tick;
    i_ld_valid = 1'b0;
    i_alu_valid = 1'b1; i_alu_addr = 5'd10; i_alu_data = 64'hAA;
    settle;
    check("ov_set", o_ld_overflow, 1);
    check("ov_stall_ready", o_alu_ready, 0);
    check("ov_pend", o_pending, 32'h406);
    tick;
    check("ov_stall_nowrite", o_write, 0);
    i_stall = 1'b0;
    settle;
    check("ov_full_ready", o_alu_ready, 0);
    tick;
    settle;
    check("ov_waddr1", o_write_addr, 1);
    check("ov_wdata1", o_write_data, 64'h11);
    check("ov_rr_ready", o_alu_ready, 0);
    tick;
    settle;
    check("ov_waddr2", o_write_addr, 2);
    check("ov_wdata2", o_write_data, 64'h22);
    check("ov_alu_ready", o_alu_ready, 1);
    tick;
    i_alu_valid = 1'b0;
    settle;
    check("ov_waddr_alu", o_write_addr, 10);
    check("ov_sticky", o_ld_overflow, 1);
    tick;
    check("ov_idle", o_write, 0);
    check("ov_sticky2", o_ld_overflow, 1);
    $display("stall overflow: 1,2 written, 3 dropped, alu 10");

    // Push and pop in the same cycle while full
    do_reset;
    i_stall = 1'b1;
    ld_push(5'd4, 64'h44);
    ld_push(5'd5, 64'h55);
    i_stall = 1'b0;
    ld_push(5'd6, 64'h66);
    settle;
    check("pp_waddr4", o_write_addr, 4);
    check("pp_wdata4", o_write_data, 64'h44);
    check("pp_no_ovf", o_ld_overflow, 0);
    tick;
    check("pp_waddr5", o_write_addr, 5);
    tick;
    check("pp_waddr6", o_write_addr, 6);
    check("pp_wdata6", o_write_data, 64'h66);
    tick;
    check("pp_idle", o_write, 0);
    $display("push+pop at full: 4,5,6 in order");

    // Writes to x0 are dropped
    i_alu_valid = 1'b1; i_alu_addr = 5'd0; i_alu_data = 64'h55;
    settle;
    check("x0_ready", o_alu_ready, 1);
    check("x0_pend", o_pending, 0);
    tick;
    i_alu_valid = 1'b0;
    settle;
    check("x0_nowrite", o_write, 0);
    check("x0_pend_after", o_pending, 0);
    $display("x0: consumed, no write");

    // Pending mask
    do_reset;
    i_stall = 1'b1;
    ld_push(5'd9, 64'h99);
    i_alu_valid = 1'b1; i_alu_addr = 5'd4; i_alu_data = 64'h4;
    settle;
    check("pm_both", o_pending, 32'h210);
    i_stall = 1'b0;
    settle;
    check("pm_ready_ld", o_alu_ready, 0);
    tick;
    settle;
    check("pm_waddr9", o_write_addr, 9);
    check("pm_mask2", o_pending, 32'h210);
    check("pm_ready_alu", o_alu_ready, 1);
    tick;
    i_alu_valid = 1'b0;
    settle;
    check("pm_waddr4", o_write_addr, 4);
    check("pm_mask3", o_pending, 32'h10);
    tick;
    check("pm_clear", o_pending, 0);
    $display("pending mask: 0x210 then drained");

    // Reset while the FIFO holds entries
    i_stall = 1'b1;
    ld_push(5'd6, 64'h6);
    ld_push(5'd8, 64'h8);
    ld_push(5'd11, 64'hB);
    settle;
    check("mr_ovf", o_ld_overflow, 1);
    check("mr_pend", o_pending, 32'h140);
    i_rst = 1'b1; i_stall = 1'b0;
    i_alu_valid = 1'b1; i_alu_addr = 5'd12; i_alu_data = 64'hC;
    settle;
    check("mr_rst_ready", o_alu_ready, 0);
    tick;
    i_rst = 1'b0; i_alu_valid = 1'b0;
    settle;
    check("mr_nowrite", o_write, 0);
    check("mr_pend_clr", o_pending, 0);
    check("mr_ovf_clr", o_ld_overflow, 0);
    tick;
    check("mr_nowrite2", o_write, 0);
    $display("mid-flight reset: queue discarded");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have i_clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have i_rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have i_alu_valid  input  1  ALU writeback request.
REQ-004 SHALL have i_alu_addr  input  5  ALU destination register.
REQ-005 SHALL have i_alu_data  input  64  ALU result.
REQ-006 SHALL have o_alu_ready  output  1  ALU request accepted this cycle.
REQ-007 SHALL have i_ld_valid  input  1  load writeback push; no backpressure.
REQ-008 SHALL have i_ld_addr  input  5  load destination register.
REQ-009 SHALL have i_ld_data  input  64  load data.
REQ-010 SHALL have i_stall  input  1  write port unavailable; no grants.
REQ-011 SHALL have o_write  output  1  register file write enable.
REQ-012 SHALL have o_write_addr  output  5  register file write address.
REQ-013 SHALL have o_write_data  output  64  register file write data.
REQ-014 SHALL have o_pending  output  32  per-register write-in-flight mask.
REQ-015 SHALL have o_ld_overflow  output  1  sticky load-queue overflow error.
REQ-016 SHALL have parameter LDQ_DEPTH, default 2, load queue depth (power of two, >=2).

Function
REQ-017 Load pushes SHALL enter a LDQ_DEPTH-entry FIFO; an entry pushed at edge N is eligible for grant from cycle N+1.
REQ-018 At most one grant per cycle SHALL be issued; no grant while i_stall=1.
REQ-019 Eligible load = FIFO non-empty; eligible ALU = i_alu_valid.
REQ-020 FIFO full SHALL force the grant to the load queue.
REQ-021 Otherwise, both eligible SHALL be resolved round-robin: grant the requester not granted at the last contested grant; single eligible requester is granted directly.
REQ-022 o_alu_ready SHALL be combinational, 1 exactly when ALU granted this cycle; ALU holds addr/data stable until ready.
REQ-023 Grant in cycle N SHALL produce o_write/o_write_addr/o_write_data registered in cycle N+1 (1-cycle latency); o_write=0 in cycles following no grant.
REQ-024 Granted requests to address 0 SHALL be consumed (ready/pop) but o_write SHALL stay 0.
REQ-025 Push and pop in same cycle SHALL be allowed at any occupancy, including full (occupancy unchanged).
REQ-026 Push while full with no pop SHALL drop the push, leave FIFO contents intact, and set o_ld_overflow until reset.
REQ-027 FIFO pointers SHALL wrap modulo LDQ_DEPTH; occupancy counter width clog2(LDQ_DEPTH)+1.
REQ-028 o_pending SHALL be combinational OR of one-hot addrs of all valid FIFO entries, pending i_alu_valid, and the output stage while o_write=1; bit 0 always 0.
REQ-029 Ordering: load entries SHALL retire in push order; no ordering between ALU and load streams beyond arbitration.

Reset
REQ-030 i_rst=1 at an edge SHALL clear FIFO (occupancy 0), o_write=0, o_write_addr=0, o_write_data=0, o_ld_overflow=0, round-robin pointer = load-first.
REQ-031 Reset mid-operation SHALL discard queued and in-flight writes; no o_write in the cycle after reset; o_alu_ready=0 while i_rst=1.

Structure
REQ-032 Shared package SHALL hold XLEN=64, REG_AW=5, NUM_REGS=32 and requester-ID enum {REQ_LD, REQ_ALU}.
REQ-033 Load FIFO SHALL be a separate sub-module regfile_wb_ldq (push, pop, head, full, empty, entry-valid/addr vector for o_pending).

Verification
REQ-034 ALU only: addr=5,data=0xA5 valid cycle 1 -> o_alu_ready cycle 1, o_write=1 addr 5 data 0xA5 cycle 2.
REQ-035 Contention: load addr 3 pushed cycle 0, ALU addr 7 valid cycles 1-2 -> cycle 1 load granted, cycle 2 ALU granted; o_write addr 3 then 7.
REQ-036 Stall overflow: i_stall=1, three load pushes -> FIFO full after two, third dropped, o_ld_overflow=1 sticky; release stall -> addrs 1,2 written in order, ALU blocked 2 cycles.
REQ-037 x0: ALU addr 0 valid -> o_alu_ready=1, o_write=0 next cycle, o_pending[0]=0.
REQ-038 Pending mask: load addr 9 queued, ALU addr 4 pending -> o_pending=0x0000_0210 until respective writes complete.
REQ-039 Reset mid-flight: FIFO holding 2 entries, i_rst one cycle -> no o_write after, o_pending=0, overflow cleared.
